px_hdl_blend_span_ctrl: RTL and testbench



---
 rtl/px_hdl_gpu_pkg.sv | 37 +++
 rtl/px_hdl_blend_span_ctrl_if.sv | 38 +++
 rtl/px_hdl_blend_core.sv | 48 ++++
 rtl/px_hdl_blend_span_ctrl.sv | 138 +++++++++++++
 tb/tb_px_hdl_blend_span_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/px_hdl_gpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | px_hdl_gpu_pkg                                                        |
// | Shared GPU pixel-path constants: ARGB8888 fields, span FSM, modes.   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package px_hdl_gpu_pkg;

    localparam int PIX_BITS = 32;
    localparam int CH_W     = 8;

    localparam int A_LSB = 24;
    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic MODE_BLEND = 1'b0;
    localparam logic MODE_COPY  = 1'b1;

    // Colour channel index 0/1/2 -> B/G/R field offset.
    function automatic int chan_lsb(input int idx);
        case (idx)
            0:       return B_LSB;
            1:       return G_LSB;
            default: return R_LSB;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/px_hdl_blend_span_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | px_hdl_blend_span_ctrl_if                                             |
// | Command plus src/dst/out stream bundle of the blend span controller. |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface px_hdl_blend_span_ctrl_if #(
    parameter int LEN_W = 16,
    parameter int PIX_W = 32
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             mode;
    logic             busy;
    logic             done;
    logic             src_valid;
    logic             src_ready;
    logic [PIX_W-1:0] src_data;
    logic             dst_valid;
    logic             dst_ready;
    logic [PIX_W-1:0] dst_data;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_data;

    modport master (
        output start, len, mode,
        output src_valid, src_data, dst_valid, dst_data, out_ready,
        input  busy, done, src_ready, dst_ready, out_valid, out_data
    );

    modport slave (
        input  start, len, mode,
        input  src_valid, src_data, dst_valid, dst_data, out_ready,
        output busy, done, src_ready, dst_ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/px_hdl_blend_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | px_hdl_blend_core                                                     |
// | Combinational ARGB8888 src-over blend with copy bypass.               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module px_hdl_blend_core
    import px_hdl_gpu_pkg::*;
(
    input  wire logic [PIX_BITS-1:0] src,
    input  wire logic [PIX_BITS-1:0] dst,
    input  wire logic                mode,
    output logic      [PIX_BITS-1:0] result
);

    logic [CH_W-1:0]     w_a1;
    logic [CH_W-1:0]     w_a2;
    logic [16:0]         w_inv_a1;
    logic [16:0]         w_a1_p1;
    logic [16:0]         w_amul;
    logic [PIX_BITS-1:0] w_blend;
    logic                w_unused_amul;

    assign w_a1     = src[A_LSB +: CH_W];
    assign w_a2     = dst[A_LSB +: CH_W];
    assign w_inv_a1 = 17'd256 - {9'd0, w_a1};
    assign w_a1_p1  = {9'd0, w_a1} + 17'd1;

    // Products never exceed 16 bits, so bit 16 is always zero.
    assign w_amul              = w_inv_a1 * (17'd255 - {9'd0, w_a2});
    assign w_blend[A_LSB +: CH_W] = 8'd255 - w_amul[15:8];
    assign w_unused_amul       = ^{w_amul[16], w_amul[7:0]};

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        localparam int c_lsb = chan_lsb(gi);
        logic [16:0] w_sum;
        logic        w_unused_sum;

        assign w_sum = (w_inv_a1 * {9'd0, dst[c_lsb +: CH_W]})
                     + ({9'd0, src[c_lsb +: CH_W]} * w_a1_p1);
        assign w_blend[c_lsb +: CH_W] = w_sum[15:8];
        assign w_unused_sum = ^{w_sum[16], w_sum[7:0]};
    end

    assign result = (mode == MODE_COPY) ? src : w_blend;

endmodule
`default_nettype wire

// File: rtl/px_hdl_blend_span_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | px_hdl_blend_span_ctrl                                                |
// | Joins src/dst pixel streams over a LEN-pixel span through a 2-stage  |
// | blend pipeline with full output backpressure.                        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module px_hdl_blend_span_ctrl
    import px_hdl_gpu_pkg::*;
#(
    parameter int LEN_W = 16,
    parameter int PIX_W = 32
)(
    input  wire logic                clk,
    input  wire logic                rst,
    px_hdl_blend_span_ctrl_if.slave  bus
);

    state_t            r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_issue_cnt;
    logic [LEN_W-1:0]  r_out_cnt;
    logic              r_mode;
    logic              r_busy;
    logic              r_done;

    logic              r_s1_vld;
    logic [PIX_W-1:0]  r_s1_src;
    logic [PIX_W-1:0]  r_s1_dst;
    logic              r_s2_vld;
    logic [PIX_W-1:0]  r_s2_data;

    logic              w_s2_load;
    logic              w_s1_free;
    logic              w_can_issue;
    logic              w_fire;
    logic              w_out_fire;
    logic [PIX_W-1:0]  w_blend;

    assign w_s2_load   = !r_s2_vld || bus.out_ready;
    assign w_s1_free   = !r_s1_vld || w_s2_load;
    assign w_can_issue = (r_state == ST_RUN) && (r_issue_cnt < r_len) && w_s1_free;
    // src and dst are joined: each side's ready waits on the other's valid.
    assign w_fire      = w_can_issue && bus.src_valid && bus.dst_valid;
    assign w_out_fire  = r_s2_vld && bus.out_ready;

    assign bus.src_ready = w_can_issue && bus.dst_valid;
    assign bus.dst_ready = w_can_issue && bus.src_valid;
    assign bus.out_valid = r_s2_vld;
    assign bus.out_data  = r_s2_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

    px_hdl_blend_core u_core (
        .src    (r_s1_src),
        .dst    (r_s1_dst),
        .mode   (r_mode),
        .result (w_blend)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_src  <= '0;
            r_s1_dst  <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_data <= '0;
        end else begin
            if (w_s2_load) begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_s2_data <= w_blend;
                end
            end
            if (w_s1_free) begin
                r_s1_vld <= w_fire;
                if (w_fire) begin
                    r_s1_src <= bus.src_data;
                    r_s1_dst <= bus.dst_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
            r_mode      <= MODE_BLEND;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_fire) begin
                r_issue_cnt <= r_issue_cnt + LEN_W'(1);
            end
            if (w_out_fire) begin
                r_out_cnt <= r_out_cnt + LEN_W'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_len       <= bus.len;
                        r_mode      <= bus.mode;
                        r_issue_cnt <= '0;
                        r_out_cnt   <= '0;
                        r_busy      <= 1'b1;
                        if (bus.len == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_fire && (r_issue_cnt == r_len - LEN_W'(1))) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_out_fire && (r_out_cnt == r_len - LEN_W'(1))) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_px_hdl_blend_span_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_px_hdl_blend_span_ctrl                                             |
// | Table vectors plus span sequences, checked through an output queue.  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_px_hdl_blend_span_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    px_hdl_blend_span_ctrl_if #(.LEN_W(16), .PIX_W(32)) bus ();

    px_hdl_blend_span_ctrl #(.LEN_W(16), .PIX_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        mode;
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [8];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];
    logic [31:0] src_pix [8];
    logic [31:0] dst_pix [8];

    int   cyc = 0, drv_cyc = 0;
    int   src_fires, dst_fires, out_fires, done_pulses;
    int   first_fire_cyc, first_out_cyc, last_out_cyc, done_cyc;
    logic busy_at_done, busy_after;
    logic [31:0] last_out;
    bit   cur_mode, streams_on, ready_toggle, ready_low, ready_seen;
    int   gap_from = -100;
    bit   stalled;
    logic [31:0] stall_data;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [31:0] blend_model(input logic md, input logic [31:0] s, input logic [31:0] d);
        logic [31:0] r;
        int a1, a2, ar;
        if (md) return s;
        a1 = int'(s[31:24]);
        a2 = int'(d[31:24]);
        ar = 255 - (((256 - a1) * (255 - a2)) / 256);
        r[31:24] = ar[7:0];
        for (int k = 0; k < 3; k++) begin
            int c1, c2, v;
            c1 = int'(s[8*k +: 8]);
            c2 = int'(d[8*k +: 8]);
            v  = ((256 - a1) * c2 + c1 * (a1 + 1)) / 256;
            r[8*k +: 8] = v[7:0];
        end
        return r;
    endfunction

    // Input driver: one update per cycle, just after the active edge.
    always @(posedge clk) begin
        #1;
        drv_cyc++;
        bus.src_valid = streams_on;
        bus.dst_valid = streams_on && !(drv_cyc >= gap_from && drv_cyc < gap_from + 2);
        bus.src_data  = src_pix[src_fires % 8];
        bus.dst_data  = dst_pix[dst_fires % 8];
        if (ready_low)         bus.out_ready = 1'b0;
        else if (ready_toggle) bus.out_ready = ~bus.out_ready;
        else                   bus.out_ready = 1'b1;
    end

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            cyc++;
            if (bus.src_ready || bus.dst_ready) ready_seen = 1'b1;
            if (bus.src_valid && bus.src_ready) begin
                if (src_fires == 0) first_fire_cyc = cyc;
                exp_q.push_back(blend_model(cur_mode, bus.src_data, bus.dst_data));
                src_fires++;
            end
            if (bus.dst_valid && bus.dst_ready) dst_fires++;
            if (stalled) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", bus.out_data, stall_data);
            end
            stalled    = bus.out_valid && !bus.out_ready;
            stall_data = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                if (out_fires == 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                out_fires++;
                last_out = bus.out_data;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: got %h expected no output", bus.out_data);
                end else begin
                    check("out_data", bus.out_data, exp_q.pop_front());
                end
            end
            if (bus.done) begin
                done_pulses++;
                done_cyc     = cyc;
                busy_at_done = bus.busy;
            end
            if (cyc == done_cyc + 1) busy_after = bus.busy;
        end
    end

    task automatic reset_stats();
        src_fires = 0; dst_fires = 0; out_fires = 0; done_pulses = 0;
        first_fire_cyc = -100; first_out_cyc = -100; last_out_cyc = -100;
        done_cyc = -100; busy_at_done = 1'b0; busy_after = 1'b1;
        ready_seen = 1'b0; last_out = 32'h0;
    endtask

    task automatic start_span(input int n, input bit md);
        @(posedge clk); #2;
        reset_stats();
        cur_mode  = md;
        bus.start = 1'b1;
        bus.len   = 16'(n);
        bus.mode  = md;
        @(posedge clk); #2;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (done_pulses == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done_pulses == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
        end
        repeat (3) @(negedge clk);
        check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'hFF112233, 32'h80AABBCC, 32'hFF112233};
        vecs[1] = '{1'b0, 32'h00FFFFFF, 32'hFF102030, 32'hFF102030};
        vecs[2] = '{1'b0, 32'h80FF0000, 32'hFF0000FF, 32'hFF80007F};
        vecs[3] = '{1'b1, 32'h00123456, 32'hDEADBEEF, 32'h00123456};
        vecs[4] = '{1'b1, 32'h7F654321, 32'h11111111, 32'h7F654321};
        vecs[5] = '{1'b0, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[6] = '{1'b0, 32'h40C86432, 32'h20102030, 32'h583E3130};
        vecs[7] = '{1'b0, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};

        rst = 1'b1;
        bus.start = 1'b0; bus.len = '0; bus.mode = 1'b0;
        bus.src_valid = 1'b0; bus.dst_valid = 1'b0; bus.out_ready = 1'b1;
        bus.src_data = '0; bus.dst_data = '0;
        streams_on = 1'b0; ready_toggle = 1'b0; ready_low = 1'b0; cur_mode = 1'b0;
        for (int i = 0; i < 8; i++) begin src_pix[i] = '0; dst_pix[i] = '0; end
        reset_stats();

        repeat (3) @(posedge clk);
        #2;
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_done",      32'(bus.done),      32'd0);
        check("rst_src_ready", 32'(bus.src_ready), 32'd0);
        check("rst_dst_ready", 32'(bus.dst_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  bus.out_data,       32'd0);
        rst = 1'b0;

        // Four-pixel span, streams always valid, sink always ready.
        for (int i = 0; i < 8; i++) begin src_pix[i] = 32'hFF112233; dst_pix[i] = 32'h80AABBCC; end
        streams_on = 1'b1;
        start_span(4, 1'b0);
        wait_done("span4", 50);
        check("span4_outs",     32'(out_fires),                     32'd4);
        check("span4_src",      32'(src_fires),                     32'd4);
        check("span4_latency",  32'(first_out_cyc - first_fire_cyc), 32'd2);
        check("span4_done_cnt", 32'(done_pulses),                   32'd1);
        check("span4_done_gap", 32'(done_cyc - last_out_cyc),       32'd1);
        check("span4_busy_done", 32'(busy_at_done),                 32'd1);
        check("span4_busy_after", 32'(busy_after),                  32'd0);
        check("span4_last",     last_out,                           32'hFF112233);

        // Table vectors, one single-pixel span each.
        for (int i = 0; i < 8; i++) begin
            src_pix[0] = vecs[i].src;
            dst_pix[0] = vecs[i].dst;
            start_span(1, vecs[i].mode);
            wait_done("vec", 30);
            check("vec_outs",  32'(out_fires), 32'd1);
            check("vec_value", last_out,       vecs[i].exp);
        end

        // Copy mode over two pixels with arbitrary destination data.
        src_pix[0] = 32'h00123456; src_pix[1] = 32'h7F654321;
        dst_pix[0] = $urandom;     dst_pix[1] = $urandom;
        start_span(2, 1'b1);
        wait_done("copy2", 30);
        check("copy2_outs", 32'(out_fires), 32'd2);
        check("copy2_last", last_out,       32'h7F654321);

        // Three pixels, toggling sink, destination gap mid-span.
        src_pix[0] = vecs[6].src; dst_pix[0] = vecs[6].dst;
        src_pix[1] = vecs[7].src; dst_pix[1] = vecs[7].dst;
        src_pix[2] = vecs[2].src; dst_pix[2] = vecs[2].dst;
        ready_toggle = 1'b1;
        gap_from = drv_cyc + 3;
        start_span(3, 1'b0);
        wait_done("stall3", 60);
        ready_toggle = 1'b0;
        check("stall3_outs", 32'(out_fires),   32'd3);
        check("stall3_src",  32'(src_fires),   32'd3);
        check("stall3_dst",  32'(dst_fires),   32'd3);
        check("stall3_done", 32'(done_pulses), 32'd1);

        // Zero-length span: immediate done, no stream handshakes.
        start_span(0, 1'b0);
        @(negedge clk);
        check("len0_done_now", 32'(bus.done), 32'd1);
        @(negedge clk);
        check("len0_done_off", 32'(bus.done), 32'd0);
        check("len0_busy_off", 32'(bus.busy), 32'd0);
        check("len0_no_ready", 32'(ready_seen), 32'd0);
        check("len0_pulses",   32'(done_pulses), 32'd1);

        // A second start while running must be ignored.
        for (int i = 0; i < 8; i++) begin src_pix[i] = vecs[6].src; dst_pix[i] = vecs[6].dst; end
        @(posedge clk); #2;
        reset_stats();
        cur_mode = 1'b0;
        gap_from = drv_cyc + 1;
        bus.start = 1'b1; bus.len = 16'd2; bus.mode = 1'b0;
        @(posedge clk); #2;
        bus.start = 1'b1; bus.len = 16'd5; bus.mode = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        wait_done("restart", 40);
        check("restart_outs",  32'(out_fires),   32'd2);
        check("restart_src",   32'(src_fires),   32'd2);
        check("restart_pulses", 32'(done_pulses), 32'd1);
        check("restart_busy",  32'(bus.busy),    32'd0);

        // Reset while the pixel waits in the output stage.
        ready_low = 1'b1;
        start_span(1, 1'b0);
        begin
            int k;
            k = 0;
            while (!bus.out_valid && k < 20) begin @(negedge clk); k++; end
        end
        check("drain_has_pixel", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy",      32'(bus.busy),      32'd0);
        check("abort_done",      32'(bus.done),      32'd0);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_out_data",  bus.out_data,       32'd0);
        check("abort_src_ready", 32'(bus.src_ready), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        check("abort_no_done", 32'(done_pulses), 32'd0);
        rst = 1'b0;
        ready_low = 1'b0;
        start_span(1, 1'b0);
        wait_done("after_abort", 30);
        check("after_abort_outs", 32'(out_fires), 32'd1);
        check("after_abort_val",  last_out,       blend_model(1'b0, vecs[6].src, vecs[6].dst));

        streams_on = 1'b0;
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
